// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port arbiter sharing one combinational memory between an
//                instruction-fetch port and a load/store data port. Data has
//                priority, with a starvation counter that forces a fetch
//                grant after a bounded run of data grants. Fixed 1-cycle
//                response latency on both ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,            // asynchronous, active-low

    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    input  logic [2:0]        d_funct3_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DWIDTH-1:0] d_rdata_o,

    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic [2:0]        mem_funct3_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    localparam logic [2:0] c_FETCH_FUNCT3 = 3'b010;           // LW
    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        DATA_PRIO   = 1'b0,
        FETCH_FORCE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_starve_cnt;
    logic [3:0]          w_starve_cnt_next;
    logic                w_if_gnt;
    logic                w_d_gnt;

    logic                r_if_rvalid;
    logic [DWIDTH-1:0]   r_if_rdata;
    logic                r_d_rvalid;
    logic [DWIDTH-1:0]   r_d_rdata;

    // Arbitration, starvation counter and next-state decode
    always_comb begin
        w_if_gnt          = 1'b0;
        w_d_gnt           = 1'b0;
        w_state_next      = r_state;
        w_starve_cnt_next = r_starve_cnt;

        // Grants are suppressed while reset is held so no memory access leaks out
        if (rst) begin
            if (r_state == FETCH_FORCE) begin
                if (if_req_i)     w_if_gnt = 1'b1;
                else if (d_req_i) w_d_gnt  = 1'b1;
            end else begin
                if (d_req_i)       w_d_gnt  = 1'b1;
                else if (if_req_i) w_if_gnt = 1'b1;
            end
        end

        // Counter tracks data grants taken while fetch is waiting
        if (!if_req_i || w_if_gnt) begin
            w_starve_cnt_next = 4'd0;
        end else if (w_d_gnt) begin
            w_starve_cnt_next = r_starve_cnt + 4'd1;
        end

        case (r_state)
            DATA_PRIO: begin
                if (w_d_gnt && if_req_i && (w_starve_cnt_next == c_STARVE_LIMIT))
                    w_state_next = FETCH_FORCE;
            end
            FETCH_FORCE: begin
                if (w_if_gnt || !if_req_i)
                    w_state_next = DATA_PRIO;
            end
            default: w_state_next = DATA_PRIO;
        endcase
    end

    // Shared memory request mux; everything is zero when nothing is granted
    always_comb begin
        mem_addr_o     = '0;
        mem_data_o     = '0;
        mem_funct3_o   = 3'b000;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        if (w_d_gnt) begin
            mem_addr_o     = d_addr_i;
            mem_data_o     = d_wdata_i;
            mem_funct3_o   = d_funct3_i;
            mem_read_en_o  = !d_we_i;
            mem_write_en_o = d_we_i;
        end else if (w_if_gnt) begin
            mem_addr_o     = if_addr_i;
            mem_funct3_o   = c_FETCH_FUNCT3;
            mem_read_en_o  = 1'b1;
        end
    end

    // FSM state and starvation counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= DATA_PRIO;
            r_starve_cnt <= 4'd0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_cnt_next;
        end
    end

    // One-cycle response: capture memory data at the grant edge, hold otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            r_if_rvalid <= w_if_gnt;
            r_d_rvalid  <= w_d_gnt;
            if (w_if_gnt) r_if_rdata <= mem_data_i;
            if (w_d_gnt)  r_d_rdata  <= d_we_i ? '0 : mem_data_i;
        end
    end

    assign if_gnt_o    = w_if_gnt;
    assign d_gnt_o     = w_d_gnt;
    assign if_rvalid_o = r_if_rvalid;
    assign if_rdata_o  = r_if_rdata;
    assign d_rvalid_o  = r_d_rvalid;
    assign d_rdata_o   = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter with a byte-addressed
//                RV32I-style memory and a streak-based arbitration model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [2:0]  d_funct3;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rd;
    logic [2:0]  mem_funct3;
    logic        mem_re, mem_we;

    int tests = 0;
    int fails = 0;

    logic        preload;
    logic [7:0]  mem [0:1023];

    // Model state: consecutive data grants taken while fetch waits, plus the
    // response registers the DUT should be showing.
    int          streak = 0;
    logic        exp_if_rvalid = 1'b0, exp_d_rvalid = 1'b0;
    logic [31:0] exp_if_rdata = '0, exp_d_rdata = '0;

    mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .STARVE_LIMIT(c_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_funct3_i(d_funct3), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_funct3_o(mem_funct3),
        .mem_read_en_o(mem_re), .mem_write_en_o(mem_we), .mem_data_i(mem_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] f);
        logic [9:0] i;
        logic [7:0] b0, b1, b2, b3;
        i  = a[9:0];
        b0 = mem[i];
        b1 = mem[i + 10'd1];
        b2 = mem[i + 10'd2];
        b3 = mem[i + 10'd3];
        case (f)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b010:  return {b3, b2, b1, b0};
            3'b100:  return {24'd0, b0};
            3'b101:  return {16'd0, b1, b0};
            default: return 32'd0;
        endcase
    endfunction

    assign mem_rd = mem_re ? mem_read(mem_addr, mem_funct3) : 32'd0;

    // Memory: preload image, then byte/half/word stores on the clock edge
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 8'h00;
            {mem[3], mem[2], mem[1], mem[0]}         <= 32'h11223344;
            {mem[7], mem[6], mem[5], mem[4]}         <= 32'h55667788;
            {mem[11], mem[10], mem[9], mem[8]}       <= 32'h99AABBCC;
            {mem[259], mem[258], mem[257], mem[256]} <= 32'hCAFEBABE;
        end else if (mem_we) begin
            mem[mem_addr[9:0]] <= mem_wdata[7:0];
            if (mem_funct3[1:0] != 2'b00) mem[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
                mem[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Per-cycle comparison against the model, then advance the model
    always @(negedge clk) begin : cmp
        logic        e_if, e_d;
        logic [31:0] e_addr, e_data;
        logic [2:0]  e_f3;
        logic        e_re, e_we;
        if (!rst) begin
            exp_if_rvalid = 1'b0; exp_d_rvalid = 1'b0;
            exp_if_rdata  = '0;   exp_d_rdata  = '0;
            streak = 0;
            e_if = 1'b0; e_d = 1'b0;
        end else begin
            e_if = if_req && (streak >= c_LIMIT || !d_req);
            e_d  = d_req && !e_if;
        end
        e_addr = e_d ? d_addr : (e_if ? if_addr : 32'd0);
        e_data = e_d ? d_wdata : 32'd0;
        e_f3   = e_d ? d_funct3 : (e_if ? 3'b010 : 3'b000);
        e_re   = e_if || (e_d && !d_we);
        e_we   = e_d && d_we;

        check1("if_gnt", if_gnt, e_if);
        check1("d_gnt", d_gnt, e_d);
        check("mem_addr", mem_addr, e_addr);
        check("mem_data", mem_wdata, e_data);
        check("mem_funct3", {29'd0, mem_funct3}, {29'd0, e_f3});
        check1("mem_read_en", mem_re, e_re);
        check1("mem_write_en", mem_we, e_we);
        check1("if_rvalid", if_rvalid, exp_if_rvalid);
        check1("d_rvalid", d_rvalid, exp_d_rvalid);
        check("if_rdata", if_rdata, exp_if_rdata);
        check("d_rdata", d_rdata, exp_d_rdata);

        if (rst) begin
            exp_if_rvalid = e_if;
            exp_d_rvalid  = e_d;
            if (e_if) exp_if_rdata = mem_read(if_addr, 3'b010);
            if (e_d)  exp_d_rdata  = d_we ? 32'd0 : mem_read(d_addr, d_funct3);
            if (!if_req || e_if) streak = 0;
            else if (e_d)        streak++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic dload(input logic [31:0] a, input logic [2:0] f);
        d_req = 1'b1; d_we = 1'b0; d_addr = a; d_funct3 = f; d_wdata = 32'd0;
    endtask

    initial begin
        rst = 1'b0; preload = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_funct3 = 3'b000;
        tick(); tick();
        preload = 1'b0;
        @(negedge clk);
        check1("reset_d_rvalid", d_rvalid, 1'b0);
        check("reset_d_rdata", d_rdata, 32'd0);
        tick(); rst = 1'b1;

        // Fetch-only back-to-back
        if_req = 1'b1; if_addr = 32'h01000000;
        @(negedge clk);
        check1("fetch0_gnt", if_gnt, 1'b1);
        check("fetch0_f3", {29'd0, mem_funct3}, 32'd2);
        tick(); if_addr = 32'h01000004;
        @(negedge clk);
        check1("fetch1_gnt", if_gnt, 1'b1);
        check("fetch0_rdata", if_rdata, 32'h11223344);
        tick(); idle();
        @(negedge clk);
        check1("fetch1_rvalid", if_rvalid, 1'b1);
        check("fetch1_rdata", if_rdata, 32'h55667788);
        tick();
        @(negedge clk);
        check1("idle_if_rvalid", if_rvalid, 1'b0);
        check("idle_if_rdata_hold", if_rdata, 32'h55667788);
        check1("idle_read_en", mem_re, 1'b0);

        // Simultaneous requests: data first, then fetch
        tick();
        if_req = 1'b1; if_addr = 32'h01000008;
        dload(32'h01000100, 3'b010);
        @(negedge clk);
        check1("sim_d_first", d_gnt, 1'b1);
        tick(); d_req = 1'b0;
        @(negedge clk);
        check1("sim_if_second", if_gnt, 1'b1);
        check("sim_d_rdata", d_rdata, 32'hCAFEBABE);
        tick(); idle();
        @(negedge clk);
        check("sim_if_rdata", if_rdata, 32'h99AABBCC);
        tick();

        // Starvation: continuous requests, fetch every fifth cycle
        if_req = 1'b1; if_addr = 32'h01000000;
        dload(32'h01000100, 3'b010);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            check1("starve_pattern", d_gnt, (k % 5) != 4);
            tick();
        end
        // Dropping fetch request mid-run restarts the count
        if_req = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        if_req = 1'b0; tick();
        if_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check1("restart_pattern", if_gnt, k == 4);
            tick();
        end
        idle(); tick();

        // Byte store then unsigned and signed byte loads
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h01000200; d_wdata = 32'h123456AB; d_funct3 = 3'b000;
        @(negedge clk);
        check1("sb_write_en", mem_we, 1'b1);
        tick(); dload(32'h01000200, 3'b100);
        @(negedge clk);
        check1("sb_ack_rvalid", d_rvalid, 1'b1);
        check("sb_ack_rdata", d_rdata, 32'd0);
        tick(); dload(32'h01000200, 3'b000);
        @(negedge clk);
        check("lbu_rdata", d_rdata, 32'h000000AB);
        tick(); idle();
        @(negedge clk);
        check("lb_rdata", d_rdata, 32'hFFFFFFAB);
        tick();

        // Reset at a clock edge: pending load response dropped, store blocked
        dload(32'h01000100, 3'b010);
        @(posedge clk);
        rst = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h01000204; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b010;
        @(negedge clk);
        check1("rst_write_en", mem_we, 1'b0);
        check1("rst_d_gnt", d_gnt, 1'b0);
        check1("rst_drop_rvalid", d_rvalid, 1'b0);
        tick(); tick();
        rst = 1'b1; idle();
        @(negedge clk);
        check1("post_rst_rvalid", d_rvalid, 1'b0);
        tick();
        dload(32'h01000204, 3'b010);
        tick(); idle();
        @(negedge clk);
        check("rst_mem_unchanged", d_rdata, 32'd0);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AWIDTH, default 32: address width of all address ports.
REQ-002 Parameter DWIDTH, default 32: data width of all data ports.
REQ-003 Parameter STARVE_LIMIT, default 4: number of consecutive data grants allowed while fetch is pending (range 1..15).
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst  input  1: reset, asynchronous and active-low.
REQ-006 if_req_i  input  1: fetch read request.
REQ-007 if_addr_i  input  AWIDTH: fetch byte address.
REQ-008 if_gnt_o  output  1: fetch request accepted this cycle.
REQ-009 if_rvalid_o  output  1: fetch read data valid.
REQ-010 if_rdata_o  output  DWIDTH: fetch read data.
REQ-011 d_req_i  input  1: data-port request.
REQ-012 d_we_i  input  1: 1 = store, 0 = load.
REQ-013 d_addr_i  input  AWIDTH: data byte address.
REQ-014 d_wdata_i  input  DWIDTH: store data.
REQ-015 d_funct3_i  input  3: load/store size and sign code (RV32I encoding).
REQ-016 d_gnt_o  output  1: data request accepted this cycle.
REQ-017 d_rvalid_o  output  1: data response valid (load data or store acknowledge).
REQ-018 d_rdata_o  output  DWIDTH: load data; 0 for a store response.
REQ-019 mem_addr_o, mem_data_o, mem_funct3_o, mem_read_en_o, mem_write_en_o  outputs: drive the shared memory's addr_i, data_i, funct3_i, read_en_i, write_en_i.
REQ-020 mem_data_i  input  DWIDTH: the shared memory's combinational data_o.

Function
REQ-021 At most one of if_gnt_o and d_gnt_o SHALL be high in any cycle; a grant is combinational from the requests and the current state, in the same cycle as the request.
REQ-022 The FSM SHALL have two states: DATA_PRIO (reset state) and FETCH_FORCE.
REQ-023 In DATA_PRIO: d_req_i high grants data; otherwise if_req_i high grants fetch.
REQ-024 In FETCH_FORCE: if_req_i high grants fetch; otherwise d_req_i high grants data.
REQ-025 A 4-bit starvation counter SHALL increment on each data grant while if_req_i is high, and clear on any fetch grant or any cycle with if_req_i low.
REQ-026 DATA_PRIO -> FETCH_FORCE when a data grant makes the counter equal STARVE_LIMIT; FETCH_FORCE -> DATA_PRIO on the next fetch grant or when if_req_i is low.
REQ-027 On a fetch grant: mem_addr_o = if_addr_i, mem_funct3_o = 3'b010, mem_read_en_o = 1, mem_write_en_o = 0.
REQ-028 On a data grant: mem_addr_o = d_addr_i, mem_funct3_o = d_funct3_i, mem_data_o = d_wdata_i, mem_read_en_o = !d_we_i, mem_write_en_o = d_we_i.
REQ-029 With no grant: all mem_* outputs = 0.
REQ-030 Response latency SHALL be exactly 1 cycle: the granted port's rvalid is high in the cycle after the grant, for one cycle; rdata registers mem_data_i at the grant edge (0 for stores).
REQ-031 Back-to-back grants SHALL be supported every cycle with no bubble; a response and a new grant to the same port may coincide.
REQ-032 rdata outputs SHALL hold their last value while rvalid is low.
REQ-033 Requesters SHALL hold request fields stable until granted; the arbiter does not buffer ungranted requests.

Reset
REQ-034 While rst is low: if_gnt_o = d_gnt_o = 0, all mem_* outputs = 0 (no memory write can occur), FSM = DATA_PRIO, counter = 0, rvalid outputs = 0, rdata outputs = 0.
REQ-035 Reset asserted mid-transaction SHALL drop any pending response; no rvalid is issued for a grant made in the cycle reset asserts.
REQ-036 The first grant SHALL be possible in the first cycle after rst rises.

Verification
REQ-037 Fetch only, addresses 0x01000000, 0x01000004 on consecutive cycles -> if_gnt_o high in both cycles, if_rvalid_o high in the next two cycles, if_rdata_o = memory words, mem_funct3_o = 010.
REQ-038 Simultaneous if_req_i and d_req_i (load 0x01000100) -> d_gnt_o first, if_gnt_o the next cycle, d_rvalid_o then if_rvalid_o in order.
REQ-039 STARVE_LIMIT = 4, continuous data and fetch requests -> data granted 4 cycles, fetch granted cycle 5, data granted cycle 6; pattern repeats.
REQ-040 SB 0xAB to 0x01000200, then LBU and LB from the same address -> store ack d_rdata_o = 0; loads return 0x000000AB and 0xFFFFFFAB.
REQ-041 rst driven low in the cycle a store is granted, at a clock edge -> mem_write_en_o = 0 immediately, memory unchanged, no d_rvalid_o after reset release.
REQ-042 Idle cycles (no requests) -> all mem_* outputs = 0, both rvalid outputs low, rdata outputs retain their previous values.
